// File: rtl/uart_pkt_loopback.sv
// Packet loopback: collects PKT_LEN received bytes, then replays them (FIFO or reversed)
// one byte per TxStart/TxDone handshake. Define UART_PKT_LOOPBACK_TIMEOUT_EN for partial flush.
module uart_pkt_loopback #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PKT_LEN     = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic              rev_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              tx_done_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_start_o,
    output logic              busy_o,
    output logic [1:0]        state_o,
    output logic [7:0]        pkt_count_o,
    output logic              overrun_o
);
    typedef enum logic [1:0] {FILL = 2'd0, GAP = 2'd1, SEND = 2'd2, WAIT = 2'd3} state_e;

    localparam int unsigned PW = ADDR_W + 1;
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    if (PKT_LEN < 2 || PKT_LEN > (1 << ADDR_W) || GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_pkt_loopback: illegal parameter combination");
    end

    state_e            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     len_q, len_d;
    logic              rev_q, rev_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [7:0]        pkt_q, pkt_d;
    logic              ovr_q, ovr_d;
    logic              buf_we;
    logic              to_fire;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] buf_mem [2**ADDR_W];

`ifdef UART_PKT_LOOPBACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_q, to_d;

    // Counts idle clocks while a partial packet sits in the buffer.
    always_comb begin
        to_d    = '0;
        to_fire = 1'b0;
        if (en_i && state_q == FILL && wr_ptr_q != '0 && !rx_valid_i) begin
            if (to_q == TW'(TIMEOUT_CYC - 1)) to_fire = 1'b1;
            else                              to_d    = to_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) to_q <= '0;
        else          to_q <= to_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    assign wr_addr = ADDR_W'(wr_ptr_q);
    // Reversed replay walks the latched length downwards.
    assign rd_addr = rev_q ? ADDR_W'(len_q - idx_q - PW'(1)) : ADDR_W'(idx_q);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        idx_d     = idx_q;
        len_d     = len_q;
        rev_d     = rev_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        pkt_d     = pkt_q;
        ovr_d     = ovr_q;
        buf_we    = 1'b0;
        if (!en_i) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            idx_d    = '0;
            gap_d    = '0;
            ovr_d    = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (rx_valid_i) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (wr_ptr_q == PW'(PKT_LEN - 1)) begin
                            state_d = GAP;
                            len_d   = PW'(PKT_LEN);
                            rev_d   = rev_i;
                            gap_d   = '0;
                        end
                    end else if (to_fire) begin
                        state_d = GAP;
                        len_d   = wr_ptr_q;
                        rev_d   = rev_i;
                        gap_d   = '0;
                    end
                end
                GAP: begin
                    ovr_d = ovr_q | rx_valid_i;
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        state_d   = SEND;
                        gap_d     = '0;
                        tx_data_d = buf_mem[rd_addr];
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                SEND: begin
                    ovr_d   = ovr_q | rx_valid_i;
                    state_d = WAIT;
                end
                WAIT: begin
                    ovr_d = ovr_q | rx_valid_i;
                    if (tx_done_i) begin
                        if (idx_q + PW'(1) == len_q) begin
                            state_d  = FILL;
                            idx_d    = '0;
                            wr_ptr_d = '0;
                            pkt_d    = pkt_q + 8'd1;
                        end else begin
                            state_d = GAP;
                            idx_d   = idx_q + PW'(1);
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= FILL;
            wr_ptr_q  <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            rev_q     <= 1'b0;
            gap_q     <= '0;
            tx_data_q <= '0;
            pkt_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            rev_q     <= rev_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            pkt_q     <= pkt_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) buf_mem[wr_addr] <= rx_data_i;
    end

    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = (state_q == SEND);
    assign busy_o      = !(state_q == FILL && wr_ptr_q == '0);
    assign state_o     = state_q;
    assign pkt_count_o = pkt_q;
    assign overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_pkt_loopback.sv
// Bench for uart_pkt_loopback: timeline model of fill/replay checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_uart_pkt_loopback;
    localparam int PL  = 8;
    localparam int GAP = 16;
    localparam int TO  = 50;
    localparam int LAT = 5;

    logic       clk = 1'b0;
    logic       rst_n, en, rev, rx_valid, tx_done;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_start, busy, overrun;
    logic [1:0] state;
    logic [7:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_pkt_loopback #(
        .DATA_W(8), .PKT_LEN(PL), .ADDR_W(4), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .rev_i(rev),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .tx_done_i(tx_done),
        .tx_data_o(tx_data), .tx_start_o(tx_start), .busy_o(busy),
        .state_o(state), .pkt_count_o(pkt_count), .overrun_o(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: collected bytes, replay list, and the absolute edge of the next TxStart.
    logic [7:0] m_pkt[$];
    logic [7:0] m_rep[$];
    int         m_start_at = -1;
    int         m_sent = 0;
    int         m_last_rx = 0;
    bit         m_inflight = 0;
    bit         m_ovr = 0;
    int         m_cnt = 0;
    logic [7:0] m_tx = 8'h00;

    logic [7:0] seen[$];
    int         start_cyc[$];
    int         done_edge[$];
    int         rx_edge = 0;
    bit         done_in_send = 0;

    function void model_reset();
        m_pkt.delete(); m_rep.delete();
        m_start_at = -1; m_sent = 0; m_inflight = 0;
        m_ovr = 0; m_cnt = 0; m_tx = 8'h00;
    endfunction

    function int m_state(int e);
        if (m_rep.size() == 0) return 0;
        if (m_start_at >= 0 && e < m_start_at) return 1;
        if (m_start_at >= 0 && e == m_start_at) return 2;
        return 3;
    endfunction

    function void launch(int n);
        m_rep.delete();
        foreach (m_pkt[k]) m_rep.push_back(rev ? m_pkt[m_pkt.size() - 1 - k] : m_pkt[k]);
        m_sent = 0;
        m_start_at = n + GAP;
    endfunction

    // Advance the model to edge n using the inputs currently applied.
    function void model_step(int n);
        int st;
        st = m_state(n - 1);
        if (!en) begin
            m_pkt.delete(); m_rep.delete();
            m_start_at = -1; m_sent = 0; m_inflight = 0; m_ovr = 0;
            return;
        end
        if (st != 0) begin
            if (rx_valid) m_ovr = 1;
            if (st == 2) begin
                m_start_at = -1;
                m_inflight = 1;
            end else if (st == 3 && tx_done) begin
                m_sent++;
                m_inflight = 0;
                if (m_sent == m_rep.size()) begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_rep.delete();
                    m_pkt.delete();
                end else begin
                    m_start_at = n + GAP;
                end
            end
        end else begin
            if (rx_valid) begin
                m_pkt.push_back(rx_data);
                m_last_rx = n;
                if (m_pkt.size() == PL) launch(n);
            end
`ifdef UART_PKT_LOOPBACK_TIMEOUT_EN
            else if (m_pkt.size() > 0 && n - m_last_rx == TO) launch(n);
`endif
        end
        if (m_start_at == n) m_tx = m_rep[m_sent];
    endfunction

    always @(negedge clk) begin
        int st;
        if (!rst_n) model_reset();
        st = m_state(cyc);
        chk("state", state, st);
        chk("tx_start", tx_start, (st == 2) ? 1 : 0);
        chk("busy", busy, (st == 0 && m_pkt.size() == 0) ? 0 : 1);
        chk("tx_data", tx_data, m_tx);
        chk("pkt_count", pkt_count, m_cnt);
        chk("overrun", overrun, m_ovr);
        if (tx_start === 1'b1) begin
            seen.push_back(tx_data);
            start_cyc.push_back(cyc);
            $display("txn: cycle %0d TxStart TxData=%02h", cyc, tx_data);
        end
        if (rst_n) begin
            if (en && rx_valid && st == 0) rx_edge = cyc + 1;
            if (en && tx_done && st == 3) done_edge.push_back(cyc + 1);
            model_step(cyc + 1);
        end
    end

    // Transmitter stand-in: TxDone LAT+1 edges after each TxStart.
    initial begin
        int pending;
        pending = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (!rst_n) pending = 0;
            else if (pending > 0) begin
                pending--;
                if (pending == 0) tx_done = 1'b1;
            end
            if (rst_n && tx_start === 1'b1) begin
                pending = LAT;
                if (done_in_send) tx_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            rx_byte(first + 8'(k));
            tick();
        end
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while ((state !== 2'd0 || busy !== 1'b0) && k < max) begin
            tick();
            k++;
        end
        chk("wait_idle_timeout", (k >= max) ? 1 : 0, 0);
    endtask

    task automatic wait_start(input int max);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (tx_start !== 1'b1 && k < max);
        chk("wait_start_timeout", (k >= max) ? 1 : 0, 0);
    endtask

    task automatic clear_obs();
        seen.delete(); start_cyc.delete(); done_edge.delete();
    endtask

    task automatic chk_seq(input string name, input logic [7:0] first, input bit down, input int n);
        chk({name, "_len"}, seen.size(), n);
        if (seen.size() == n)
            for (int k = 0; k < n; k++)
                chk(name, seen[k], down ? first - 8'(k) : first + 8'(k));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx8;
        rst_n = 1'b1; en = 1'b0; rev = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", state, 0);
        chk("reset_busy", busy, 0);
        chk("reset_tx_data", tx_data, 0);
        repeat (2) tick();
        rst_n = 1'b1; en = 1'b1;
        tick();

        // FIFO replay; Rev flipped during replay must not matter
        clear_obs();
        send_bytes(8'h11, PL);
        rx8 = rx_edge;
        rev = 1'b1;
        wait_idle(600);
        chk_seq("s1_data", 8'h11, 0, PL);
        if (start_cyc.size() == PL && done_edge.size() >= PL - 1) begin
            chk("s1_first_gap", start_cyc[0] - rx8, 16);
            for (int k = 1; k < PL; k++) chk("s1_done_gap", start_cyc[k] - done_edge[k-1], 16);
        end
        chk("s1_pktcount", pkt_count, 1);

        // Reversed replay, with a stray TxDone in every SEND clock
        clear_obs();
        done_in_send = 1;
        send_bytes(8'h11, PL);
        rev = 1'b0;
        wait_idle(600);
        done_in_send = 0;
        chk_seq("s2_data", 8'h18, 1, PL);
        chk("s2_pktcount", pkt_count, 2);

        // Extra byte during WAIT sets Overrun, replay unchanged
        clear_obs();
        send_bytes(8'h21, PL);
        wait_start(100);
        tick();
        rx_byte(8'hAA);
        chk("s3_overrun_set", overrun, 1);
        wait_idle(600);
        chk_seq("s3_data", 8'h21, 0, PL);
        chk("s3_pktcount", pkt_count, 3);

        // Next packet unaffected; byte coincident with final TxDone is dropped
        clear_obs();
        send_bytes(8'h31, PL);
        for (int k = 0; k < PL; k++) wait_start(100);
        repeat (LAT) tick();
        rx_byte(8'h55);
        wait_idle(100);
        chk_seq("s3b_data", 8'h31, 0, PL);
        chk("s3b_pktcount", pkt_count, 4);
        chk("s3b_overrun_sticky", overrun, 1);
        chk("s3b_busy", busy, 0);

        // En low for one clock mid-fill (with a byte that must be ignored)
        clear_obs();
        send_bytes(8'h61, 5);
        en = 1'b0;
        rx_byte(8'h99);
        en = 1'b1;
        chk("s5_overrun_clr", overrun, 0);
        chk("s5_busy_clr", busy, 0);
        send_bytes(8'h71, 3);
        chk("s5_still_fill", state, 0);
        chk("s5_no_start", seen.size(), 0);
        send_bytes(8'h74, 5);
        wait_idle(600);
        chk_seq("s5_data", 8'h71, 0, PL);
        chk("s5_pktcount", pkt_count, 5);

        // Asynchronous reset after the 3rd TxStart
        clear_obs();
        send_bytes(8'h41, PL);
        for (int k = 0; k < 3; k++) wait_start(100);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_rst_state", state, 0);
        chk("s4_rst_tx_start", tx_start, 0);
        chk("s4_rst_tx_data", tx_data, 0);
        chk("s4_rst_busy", busy, 0);
        chk("s4_rst_pktcount", pkt_count, 0);
        chk("s4_rst_overrun", overrun, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_obs();
        send_bytes(8'h51, PL);
        wait_idle(600);
        chk_seq("s4_data", 8'h51, 0, PL);
        chk("s4_pktcount", pkt_count, 1);

        // Three bytes then silence
        clear_obs();
        send_bytes(8'h91, 3);
        rx8 = rx_edge;
`ifdef UART_PKT_LOOPBACK_TIMEOUT_EN
        wait_idle(400);
        chk_seq("s6_data", 8'h91, 0, 3);
        if (start_cyc.size() > 0) chk("s6_flush_delay", start_cyc[0] - rx8, TO + GAP);
        chk("s6_pktcount", pkt_count, 2);
`else
        repeat (200) tick();
        chk("s6_no_start", seen.size(), 0);
        chk("s6_state", state, 0);
        chk("s6_busy", busy, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_pkt_loopback.md
UART_PKT_LOOPBACK -- requirements
Module: uart_pkt_loopback

Interface
REQ-001 Parameters SHALL be:
  DATA_W, 8, byte width.
  PKT_LEN, 8, bytes per packet, 2..2^ADDR_W.
  ADDR_W, 4, buffer address width.
  GAP_CYC, 16, clocks from end of fill, or from TxDone, to next TxStart; minimum 1.
  TIMEOUT_CYC, 100000, idle clocks before partial flush (TIMEOUT_EN only).
REQ-002 Ports SHALL be:
  Clk       in   1       single clock, rising edge.
  Rst_n     in   1       asynchronous, active-low reset.
  En        in   1       block enable.
  Rev       in   1       replay order: 0 = FIFO, 1 = reversed.
  RxData    in   DATA_W  received byte.
  RxValid   in   1       one-cycle strobe qualifying RxData.
  TxDone    in   1       one-cycle pulse from transmitter at end of byte.
  TxData    out  DATA_W  byte to transmit.
  TxStart   out  1       one-cycle transmit request.
  Busy      out  1       high outside FILL with zero bytes.
  State     out  2       current FSM state encoding.
  PktCount  out  8       completed replays, wraps 255->0.
  Overrun   out  1       sticky: RxValid dropped during replay.
REQ-003 Clock and reset: one clock, Clk; Rst_n is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be FILL=0, GAP=1, SEND=2, WAIT=3.
REQ-005 FILL SHALL write RxData to buffer[WrPtr] on each RxValid and increment WrPtr.
REQ-006 On the RxValid that makes WrPtr equal PKT_LEN, FILL SHALL go to GAP.
  - Len SHALL be latched as PKT_LEN.
  - Rev SHALL be latched for the whole replay.
REQ-007 GAP SHALL count GAP_CYC clocks and then go to SEND.
REQ-008 SEND SHALL last exactly one clock.
  - TxStart=1 during that clock.
  - TxData=buffer[RdIdx], where RdIdx = i for FIFO order and Len-1-i for reversed order, i = bytes already sent.
  - Next state SHALL be WAIT.
REQ-009 TxData SHALL hold its value from SEND until TxDone is received.
REQ-010 In WAIT, TxDone SHALL increment i.
  - If i reaches Len: PktCount+1, WrPtr=0, i=0, go to FILL.
  - Otherwise: go to GAP.
REQ-011 RxValid in GAP, SEND or WAIT SHALL be dropped and SHALL set Overrun; buffer is unchanged.
REQ-012 TxDone outside WAIT SHALL be ignored.
REQ-013 TxDone in the SEND clock SHALL be ignored; no byte is skipped.
REQ-014 RxValid coincident with the TxDone that ends a replay SHALL be dropped and SHALL set Overrun.
REQ-015 When En=0, the next clock SHALL force FILL.
  - WrPtr=0, i=0, TxStart=0.
  - Any in-flight replay is aborted without a PktCount increment.
  - Overrun SHALL be cleared.
  - RxValid SHALL be ignored while En=0.
REQ-016 Buffer SHALL be an internal 2^ADDR_W x DATA_W register array with synchronous write, not reset.
REQ-017 Busy SHALL equal NOT(State==FILL AND WrPtr==0).

Reset
REQ-018 Rst_n=0 SHALL immediately set the following, regardless of Clk or mid-packet/mid-replay state:
  - State=FILL.
  - WrPtr=0, i=0, all counters 0.
  - TxStart=0, TxData=0, Busy=0, PktCount=0, Overrun=0.
REQ-019 Deassertion SHALL take effect on the first Clk edge with Rst_n=1; buffer contents are don't-care.

Configuration
REQ-020 The macro UART_PKT_LOOPBACK_TIMEOUT_EN SHALL control partial-packet flush.
  - Defined: in FILL with WrPtr>0, TIMEOUT_CYC consecutive clocks without RxValid SHALL latch Len=WrPtr and go to GAP. Any RxValid restarts the count.
  - Undefined: FILL waits indefinitely, and no timeout counter SHALL be synthesised.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - Bytes 0x11..0x18 with Rev=0, GAP_CYC=16: TxStart 16 clocks after the 8th RxValid; TxData sequence 0x11..0x18; each TxStart 16 clocks after the previous TxDone; PktCount=1.
  - Same bytes with Rev=1: TxData sequence 0x18..0x11.
  - Extra RxValid (0xAA) during WAIT: Overrun=1; replay data unchanged; next packet is unaffected.
  - Rst_n pulsed low after the 3rd TxStart: all outputs 0 asynchronously; a new 8-byte packet replays correctly.
  - En=0 for 1 clock mid-fill (5 bytes): 8 further bytes are then needed to trigger replay; no PktCount increment.
  - TIMEOUT_EN defined, TIMEOUT_CYC=50, 3 bytes then silence: replay of 3 bytes starts 50+16 clocks after the last RxValid. Undefined: no TxStart.
